// File: rtl/pdl_dll_ctrl.sv
// pdl_dll_ctrl: delay-code controller for the 64-tap RXCLK programmable delay line.
//
// Selects the delay code either from configuration (manual mode) or by a
// closed-loop calibration: sweep the code upward until the synchronized phase
// detector reads "late", confirm it after one more settle period, then track
// drift with a filtered up/down loop.
//
// Ports:
//   clk_i         controller clock
//   rst_ni        asynchronous active-low reset
//   cfg_manual_i  1 = code follows cfg_code_i, loop disabled
//   cfg_code_i    manual code 0..64 (larger values clamp to 64)
//   cal_start_i   single-cycle calibration start pulse
//   track_en_i    enables drift tracking once locked
//   pd_in_i       asynchronous phase-detector output (1 = delayed clock late)
//   bk_o          thermometer stage enables, bk_o[i] = (i < code), one cycle after code_o
//   code_o        current delay code 0..64
//   busy_o        calibration sweep / lock confirmation in progress
//   lock_o        locked and tracking
//   cal_err_o     sticky calibration failure flag
module pdl_dll_ctrl #(
  parameter int unsigned SETTLE_CYC = 16,
  parameter int unsigned FILT_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cfg_manual_i,
  input  logic [6:0]  cfg_code_i,
  input  logic        cal_start_i,
  input  logic        track_en_i,
  input  logic        pd_in_i,
  output logic [63:0] bk_o,
  output logic [6:0]  code_o,
  output logic        busy_o,
  output logic        lock_o,
  output logic        cal_err_o
);

  localparam int unsigned CW = $clog2(SETTLE_CYC) + 1;
  localparam int unsigned FW = $clog2(FILT_DEPTH + 1) + 1;

  localparam logic [CW-1:0]        SETTLE_LOAD = CW'(SETTLE_CYC);
  // Filter value one vote short of a code step in each direction.
  localparam logic signed [FW-1:0] FILT_UP     = FW'(FILT_DEPTH - 1);
  localparam logic signed [FW-1:0] FILT_DN     = -FILT_UP;
  localparam logic [6:0]           CODE_MAX    = 7'd64;
  localparam logic [63:0]          ONES        = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_LOCK_CHK,
    ST_TRACK,
    ST_FAIL
  } state_e;

  state_e                 state_q, state_d;
  logic [6:0]             code_q, code_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic signed [FW-1:0]   filt_q, filt_d;
  logic                   cal_err_q, cal_err_d;
  logic [63:0]            bk_q;
  logic                   busy_q, lock_q;
  logic                   pd_meta_q, pd_s_q;
  logic                   start_ok;

  // cal_start is only honoured outside the sweep/confirm states.
  assign start_ok = (state_q == ST_IDLE) || (state_q == ST_TRACK) || (state_q == ST_FAIL);

  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    cnt_d     = cnt_q;
    filt_d    = filt_q;
    cal_err_d = cal_err_q;

    if (cfg_manual_i) begin
      state_d = ST_IDLE;
      code_d  = (cfg_code_i > CODE_MAX) ? CODE_MAX : cfg_code_i;
      filt_d  = '0;
    end else if (cal_start_i && start_ok) begin
      state_d   = ST_SETTLE;
      code_d    = '0;
      cnt_d     = SETTLE_LOAD;
      filt_d    = '0;
      cal_err_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: state_d = ST_IDLE;

        ST_SETTLE: begin
          if (cnt_q <= CW'(1)) state_d = ST_SAMPLE;
          else                 cnt_d   = cnt_q - CW'(1);
        end

        ST_SAMPLE: begin
          if (pd_s_q) begin
            state_d = ST_LOCK_CHK;
            cnt_d   = SETTLE_LOAD;
          end else if (code_q == CODE_MAX) begin
            state_d   = ST_FAIL;
            cal_err_d = 1'b1;
          end else begin
            state_d = ST_SETTLE;
            code_d  = code_q + 7'd1;
            cnt_d   = SETTLE_LOAD;
          end
        end

        // Counts down a full settle period, then re-samples in the same
        // state, so confirmation costs SETTLE_CYC+1 cycles like a sweep step.
        ST_LOCK_CHK: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
          end else if (pd_s_q) begin
            state_d = ST_TRACK;
            cnt_d   = SETTLE_LOAD;
            filt_d  = '0;
          end else if (code_q == CODE_MAX) begin
            state_d   = ST_FAIL;
            cal_err_d = 1'b1;
          end else begin
            state_d = ST_SETTLE;
            code_d  = code_q + 7'd1;
            cnt_d   = SETTLE_LOAD;
          end
        end

        ST_TRACK: begin
          if (!track_en_i) begin
            cnt_d  = SETTLE_LOAD;
            filt_d = '0;
          end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
          end else begin
            cnt_d = SETTLE_LOAD;
            if (!pd_s_q) begin
              // Up vote; a direction reversal only clears the filter.
              if (filt_q[FW-1]) begin
                filt_d = '0;
              end else if (filt_q == FILT_UP) begin
                filt_d = '0;
                if (code_q != CODE_MAX) code_d = code_q + 7'd1;
              end else begin
                filt_d = filt_q + FW'(1);
              end
            end else begin
              if (!filt_q[FW-1] && (filt_q != '0)) begin
                filt_d = '0;
              end else if (filt_q == FILT_DN) begin
                filt_d = '0;
                if (code_q != '0) code_d = code_q - 7'd1;
              end else begin
                filt_d = filt_q - FW'(1);
              end
            end
          end
        end

        ST_FAIL: code_d = CODE_MAX;

        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      code_q    <= '0;
      cnt_q     <= '0;
      filt_q    <= '0;
      cal_err_q <= 1'b0;
      bk_q      <= '0;
      busy_q    <= 1'b0;
      lock_q    <= 1'b0;
      pd_meta_q <= 1'b0;
      pd_s_q    <= 1'b0;
    end else begin
      pd_meta_q <= pd_in_i;
      pd_s_q    <= pd_meta_q;
      state_q   <= state_d;
      code_q    <= code_d;
      cnt_q     <= cnt_d;
      filt_q    <= filt_d;
      cal_err_q <= cal_err_d;
      busy_q    <= (state_d == ST_SETTLE) || (state_d == ST_SAMPLE) || (state_d == ST_LOCK_CHK);
      lock_q    <= (state_d == ST_TRACK);
      // Thermometer from the registered code: a shift by 64 yields all ones.
      bk_q      <= ~(ONES << code_q);
    end
  end

  assign bk_o      = bk_q;
  assign code_o    = code_q;
  assign busy_o    = busy_q;
  assign lock_o    = lock_q;
  assign cal_err_o = cal_err_q;

endmodule

// File: tb/tb_pdl_dll_ctrl.sv
// Self-checking bench for pdl_dll_ctrl. The delay line and phase detector are
// modelled as pd = (number of enabled stages >= threshold), with optional
// per-cycle toggling and a one-sample glitch at level 10.
module tb_pdl_dll_ctrl;

  localparam int unsigned S = 16;
  localparam int unsigned D = 4;
  localparam int unsigned P = S + 1;

  logic        clk_i        = 1'b0;
  logic        rst_ni       = 1'b0;
  logic        cfg_manual_i = 1'b0;
  logic [6:0]  cfg_code_i   = '0;
  logic        cal_start_i  = 1'b0;
  logic        track_en_i   = 1'b0;
  logic        pd_in_i      = 1'b0;
  logic [63:0] bk_o;
  logic [6:0]  code_o;
  logic        busy_o;
  logic        lock_o;
  logic        cal_err_o;

  int tests = 0;
  int fails = 0;

  pdl_dll_ctrl #(.SETTLE_CYC(S), .FILT_DEPTH(D)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .cfg_manual_i(cfg_manual_i),
    .cfg_code_i  (cfg_code_i),
    .cal_start_i (cal_start_i),
    .track_en_i  (track_en_i),
    .pd_in_i     (pd_in_i),
    .bk_o        (bk_o),
    .code_o      (code_o),
    .busy_o      (busy_o),
    .lock_o      (lock_o),
    .cal_err_o   (cal_err_o)
  );

  always #5 clk_i = ~clk_i;

  // Delay line + phase detector environment model.
  int unsigned thr = 1000;
  bit          toggle_mode = 1'b0;
  bit          glitch_en = 1'b0;
  int unsigned lvl_prev = 0;
  int unsigned lvl_age = 0;

  always @(negedge clk_i) begin
    int unsigned lvl;
    lvl = $countones(bk_o);
    if (lvl == lvl_prev) lvl_age = lvl_age + 1;
    else                 lvl_age = 0;
    lvl_prev = lvl;
    if (toggle_mode)                                    pd_in_i = ~pd_in_i;
    else if (glitch_en && (lvl == 10) && (lvl_age < 20)) pd_in_i = 1'b1;
    else                                                pd_in_i = (lvl >= thr);
  end

  function automatic logic [63:0] therm(input int unsigned c);
    logic [63:0] r;
    r = '0;
    for (int unsigned i = 0; i < 64; i++) if (i < c) r[i] = 1'b1;
    return r;
  endfunction

  function automatic int unsigned clamp64(input int unsigned c);
    return (c > 64) ? 64 : c;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic pulse_cal();
    @(negedge clk_i);
    cal_start_i = 1'b1;
    @(negedge clk_i);
    cal_start_i = 1'b0;
  endtask

  // Returns the number of cycles until lock or cal_err, or max+1 on timeout.
  task automatic wait_done(input int unsigned max, output int unsigned cyc);
    cyc = max + 1;
    for (int unsigned i = 1; i <= max; i++) begin
      @(negedge clk_i);
      if (lock_o || cal_err_o) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic wait_code_change(input logic [6:0] from, input int unsigned max,
                                  output int unsigned cyc);
    cyc = max + 1;
    for (int unsigned i = 1; i <= max; i++) begin
      @(negedge clk_i);
      if (code_o != from) begin
        cyc = i;
        break;
      end
    end
  endtask

  // Lock is expected (k+2) sample periods after the start pulse for a
  // threshold at code k, one extra period per rejected glitch.
  task automatic calibrate(input string name, input int unsigned t,
                           input int unsigned exp_code, input int unsigned exp_cyc);
    int unsigned cyc;
    thr = t;
    pulse_cal();
    check({name, " busy_after_start"}, 64'(busy_o), 64'd1);
    check({name, " code_after_start"}, 64'(code_o), 64'd0);
    wait_done(exp_cyc + 50, cyc);
    check({name, " latency"}, 64'(cyc), 64'(exp_cyc));
    check({name, " lock"}, 64'(lock_o), 64'd1);
    check({name, " code"}, 64'(code_o), 64'(exp_code));
    check({name, " busy"}, 64'(busy_o), 64'd0);
    check({name, " bk"}, bk_o, therm(exp_code));
  endtask

  typedef struct {
    logic [6:0]  cfg;
    logic [6:0]  exp_code;
    logic [63:0] exp_bk;
  } vec_t;

  initial begin
    vec_t        vecs[8];
    int unsigned cyc;
    int unsigned r;

    vecs[0] = '{7'd5,   7'd5,  64'h0000_0000_0000_001F};
    vecs[1] = '{7'd0,   7'd0,  64'h0000_0000_0000_0000};
    vecs[2] = '{7'd1,   7'd1,  64'h0000_0000_0000_0001};
    vecs[3] = '{7'd63,  7'd63, 64'h7FFF_FFFF_FFFF_FFFF};
    vecs[4] = '{7'd64,  7'd64, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[5] = '{7'd65,  7'd64, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[6] = '{7'd127, 7'd64, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[7] = '{7'd23,  7'd23, 64'h0000_0000_007F_FFFF};

    #1;
    check("rst bk", bk_o, 64'd0);
    check("rst code", 64'(code_o), 64'd0);
    check("rst busy", 64'(busy_o), 64'd0);
    check("rst lock", 64'(lock_o), 64'd0);
    check("rst cal_err", 64'(cal_err_o), 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (3) @(negedge clk_i);
    check("idle code", 64'(code_o), 64'd0);
    check("idle busy", 64'(busy_o), 64'd0);

    // Threshold at code 0: fastest possible lock.
    calibrate("cal_k0", 0, 0, 2 * P);
    calibrate("cal_k23", 23, 23, 25 * P);
    check("cal_k23 bk_const", bk_o, 64'h0000_0000_007F_FFFF);

    // One-sample glitch at code 10 must be rejected.
    glitch_en = 1'b1;
    calibrate("glitch", 30, 30, 33 * P);
    glitch_en = 1'b0;

    for (int n = 0; n < 3; n++) begin
      r = $urandom_range(1, 40);
      calibrate("cal_rand", r, r, (r + 2) * P);
    end

    // Tracking: alternating votes must not move the code.
    calibrate("trk_lock", 23, 23, 25 * P);
    toggle_mode = 1'b1;
    track_en_i  = 1'b1;
    repeat (20 * P) @(negedge clk_i);
    check("trk alt code", 64'(code_o), 64'd23);
    check("trk alt lock", 64'(lock_o), 64'd1);
    track_en_i  = 1'b0;
    toggle_mode = 1'b0;
    thr         = 25;
    repeat (3) @(negedge clk_i);
    check("trk frozen code", 64'(code_o), 64'd23);
    check("trk frozen lock", 64'(lock_o), 64'd1);
    track_en_i = 1'b1;
    wait_code_change(7'd23, 6 * P, cyc);
    check("trk step1 cycles", 64'(cyc), 64'(D * P));
    check("trk step1 code", 64'(code_o), 64'd24);
    wait_code_change(7'd24, 6 * P, cyc);
    check("trk step2 cycles", 64'(cyc), 64'(D * P));
    check("trk step2 code", 64'(code_o), 64'd25);
    repeat (2 * P) @(negedge clk_i);
    check("trk hold code", 64'(code_o), 64'd25);
    check("trk hold bk", bk_o, therm(25));
    track_en_i = 1'b0;

    // Manual override from the tracking state.
    cfg_code_i = 7'd100;
    @(negedge clk_i);
    check("man pre code", 64'(code_o), 64'd25);
    cfg_manual_i = 1'b1;
    @(negedge clk_i);
    check("man clamp code", 64'(code_o), 64'd64);
    check("man lock", 64'(lock_o), 64'd0);
    pulse_cal();
    check("man cal ignored busy", 64'(busy_o), 64'd0);
    check("man cal ignored code", 64'(code_o), 64'd64);

    for (int unsigned v = 0; v < 8; v++) begin
      cfg_code_i = vecs[v].cfg;
      @(negedge clk_i);
      check("vec code", 64'(code_o), 64'(vecs[v].exp_code));
      @(negedge clk_i);
      check("vec bk", bk_o, vecs[v].exp_bk);
    end

    for (int n = 0; n < 30; n++) begin
      r = $urandom_range(0, 127);
      cfg_code_i = 7'(r);
      @(negedge clk_i);
      check("rand man code", 64'(code_o), 64'(clamp64(r)));
      @(negedge clk_i);
      check("rand man bk", bk_o, therm(clamp64(r)));
    end

    cfg_code_i = 7'd5;
    repeat (2) @(negedge clk_i);
    cfg_manual_i = 1'b0;
    repeat (5) @(negedge clk_i);
    check("man exit code", 64'(code_o), 64'd5);
    check("man exit busy", 64'(busy_o), 64'd0);
    check("man exit lock", 64'(lock_o), 64'd0);

    // Calibration failure: detector never reports late.
    thr = 1000;
    pulse_cal();
    wait_done(65 * P + 50, cyc);
    check("fail cycles", 64'(cyc), 64'(65 * P));
    check("fail cal_err", 64'(cal_err_o), 64'd1);
    check("fail code", 64'(code_o), 64'd64);
    check("fail bk", bk_o, 64'hFFFF_FFFF_FFFF_FFFF);
    check("fail lock", 64'(lock_o), 64'd0);
    check("fail busy", 64'(busy_o), 64'd0);
    repeat (5) @(negedge clk_i);
    check("fail sticky", 64'(cal_err_o), 64'd1);
    thr = 5;
    pulse_cal();
    check("restart cal_err clr", 64'(cal_err_o), 64'd0);
    check("restart busy", 64'(busy_o), 64'd1);
    wait_done(7 * P + 50, cyc);
    check("restart lock", 64'(lock_o), 64'd1);
    check("restart code", 64'(code_o), 64'd5);

    // Asynchronous reset mid-sweep.
    thr = 50;
    pulse_cal();
    repeat (100) @(negedge clk_i);
    #2;
    rst_ni = 1'b0;
    #1;
    check("arst bk", bk_o, 64'd0);
    check("arst code", 64'(code_o), 64'd0);
    check("arst busy", 64'(busy_o), 64'd0);
    check("arst lock", 64'(lock_o), 64'd0);
    check("arst cal_err", 64'(cal_err_o), 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (5 * P) @(negedge clk_i);
    check("post rst code", 64'(code_o), 64'd0);
    check("post rst busy", 64'(busy_o), 64'd0);
    check("post rst lock", 64'(lock_o), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
